multiplier: RTL and testbench

// - Sequential unsigned shift-add multiplier: N-bit MP x N-bit MC -> 2N-bit product.
// - Processes one multiplier bit per enabled clock.
// - Exposes the current multiplier LSB (b0) and an add-select input (Psel), so an

---
 rtl/multiplier_pkg.sv | 13 +
 rtl/multiplier_if.sv | 25 ++
 rtl/mult_datapath.sv | 40 ++++
 rtl/multiplier.sv | 36 +++
 tb/tb_multiplier.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/multiplier_pkg.sv
// Shared widths and types for the shift-add multiplier.
package multiplier_pkg;
    localparam int N  = 8;
    localparam int PW = 2 * N;

    typedef logic [N-1:0]  opnd_t;
    typedef logic [PW-1:0] prod_t;

    // Zero-extend an operand to product width.
    function automatic prod_t widen(opnd_t v);
        return {{N{1'b0}}, v};
    endfunction
endpackage

// File: rtl/multiplier_if.sv
// Operand/control/result bundle between the controller (master) and the multiplier (slave).
interface multiplier_if;
    import multiplier_pkg::*;

    opnd_t MP;
    opnd_t MC;
    logic  load;
    logic  enable;
    logic  Psel;
    logic  zero_flag;
    logic  b0;
    prod_t product;

    // load/enable are level controls sampled on each rising edge; there is no
    // valid/ready handshake. Completion is signalled by zero_flag going high.
    modport master (
        output MP, MC, load, enable, Psel,
        input  zero_flag, b0, product
    );

    modport slave (
        input  MP, MC, load, enable, Psel,
        output zero_flag, b0, product
    );
endinterface

// File: rtl/mult_datapath.sv
// Shift registers and accumulator for the shift-add multiplier.
module mult_datapath
    import multiplier_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_en,
    input  logic  step_en,
    input  logic  add_en,
    input  opnd_t mp_in,
    input  opnd_t mc_in,
    output opnd_t mp_q,
    output prod_t prod_q
);
    opnd_t mp_r;
    prod_t mc_r;
    prod_t prod_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mp_r   <= '0;
            mc_r   <= '0;
            prod_r <= '0;
        end else if (load_en) begin
            mp_r   <= mp_in;
            mc_r   <= widen(mc_in);
            prod_r <= '0;
        end else if (step_en) begin
            // Carry out of the 2N-bit sum is dropped; it cannot occur when add_en follows b0.
            if (add_en) begin
                prod_r <= prod_r + mc_r;
            end
            mc_r <= mc_r << 1;
            mp_r <= mp_r >> 1;
        end
    end

    assign mp_q   = mp_r;
    assign prod_q = prod_r;
endmodule

// File: rtl/multiplier.sv
// Shift-add multiplier top: load/enable priority decode plus status outputs.
module multiplier
    import multiplier_pkg::*;
(
    input logic          clk,
    input logic          rst,
    multiplier_if.slave  bus
);
    opnd_t mp_q;
    prod_t prod_q;
    logic  load_en;
    logic  step_en;
    logic  zero_flag;

    assign zero_flag = (mp_q == '0);

    // load wins over enable; stepping stops by itself once the multiplier is exhausted.
    assign load_en = bus.load;
    assign step_en = !bus.load && bus.enable && !zero_flag;

    mult_datapath u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .step_en (step_en),
        .add_en  (bus.Psel),
        .mp_in   (bus.MP),
        .mc_in   (bus.MC),
        .mp_q    (mp_q),
        .prod_q  (prod_q)
    );

    assign bus.zero_flag = zero_flag;
    assign bus.b0        = mp_q[0];
    assign bus.product   = prod_q;
endmodule

// File: tb/tb_multiplier.sv
// Randomised and directed checks of the shift-add multiplier against an arithmetic model.
module tb_multiplier;
    import multiplier_pkg::*;

    logic clk;
    logic rst;

    multiplier_if bus ();

    assign bus.Psel = bus.b0;

    multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [PW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic prod_t model_product(opnd_t mp, opnd_t mc);
        return prod_t'(int'(mp) * int'(mc));
    endfunction

    function automatic int model_latency(opnd_t mp);
        int k = 0;
        for (int i = 0; i < N; i++) if (mp[i]) k = i + 1;
        return k;
    endfunction

    // Product after the first k multiplier bits have been consumed.
    function automatic prod_t model_partial(opnd_t mp, opnd_t mc, int k);
        int sum = 0;
        for (int i = 0; i < k; i++) if (mp[i]) sum += int'(mc) * (1 << i);
        return prod_t'(sum);
    endfunction

    function automatic logic model_b0(opnd_t mp, int k);
        return ((int'(mp) >> k) & 1) == 1;
    endfunction

    // ---------------- monitor ----------------
    logic  last_load;
    logic  rst_hit = 1'b0;
    logic  prev_zf;
    logic  done_valid;
    prod_t hold_val;

    always @(posedge clk or posedge rst) begin
        if (rst) last_load <= 1'b0;
        else     last_load <= bus.load;
    end

    always @(posedge rst) rst_hit = 1'b1;

    initial begin
        prev_zf    = 1'b1;
        done_valid = 1'b1;
        hold_val   = '0;
        forever begin
            @(negedge clk);
            if (rst || rst_hit) begin
                rst_hit    = 1'b0;
                prev_zf    = 1'b1;
                done_valid = 1'b1;
                hold_val   = '0;
            end else begin
                if (bus.zero_flag && (!prev_zf || last_load)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'(bus.product), 32'hFFFF_FFFF);
                    end else begin
                        hold_val = exp_q.pop_front();
                        check("final_product", 32'(bus.product), 32'(hold_val));
                    end
                    done_valid = 1'b1;
                end else if (bus.zero_flag && done_valid) begin
                    check("product_hold", 32'(bus.product), 32'(hold_val));
                end else if (!bus.zero_flag) begin
                    done_valid = 1'b0;
                end
                prev_zf = bus.zero_flag;
            end
        end
    end

    // ---------------- driver tasks (enter and leave at posedge + 1) ----------------
    task automatic do_load(input opnd_t mp, input opnd_t mc);
        bus.MP     = mp;
        bus.MC     = mc;
        bus.load   = 1'b1;
        bus.enable = 1'b0;
        @(posedge clk); #1;
        bus.load   = 1'b0;
        bus.MP     = opnd_t'($urandom);
        bus.MC     = opnd_t'($urandom);
    endtask

    task automatic step(input logic en);
        bus.enable = en;
        @(posedge clk); #1;
    endtask

    task automatic drive_until_done(input int gap_pct, output int cycles);
        int iter = 0;
        cycles = 0;
        while (!bus.zero_flag && iter < 200) begin
            logic en;
            en = ($urandom_range(0, 99) >= gap_pct);
            step(en);
            if (en) cycles++;
            iter++;
        end
        if (!bus.zero_flag) check("run_timeout", 32'(bus.zero_flag), 32'd1);
    endtask

    task automatic run(input opnd_t mp, input opnd_t mc, input int gap_pct, input string tag);
        int cycles;
        exp_q.push_back(model_product(mp, mc));
        do_load(mp, mc);
        drive_until_done(gap_pct, cycles);
        check({tag, "_latency"}, 32'(cycles), 32'(model_latency(mp)));
        repeat (3) step(1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_product"}, 32'(bus.product), 32'd0);
        check({tag, "_zero_flag"}, 32'(bus.zero_flag), 32'd1);
        check({tag, "_b0"}, 32'(bus.b0), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cycles;
        rst        = 1'b1;
        bus.load   = 1'b1;
        bus.enable = 1'b1;
        bus.MP     = 8'h83;
        bus.MC     = 8'h03;
        #1;
        check_reset_outputs("reset_t0");
        repeat (3) begin
            @(posedge clk); #1;
            check_reset_outputs("reset_edge");
        end
        rst        = 1'b0;
        bus.load   = 1'b0;
        bus.enable = 1'b0;
        step(1'b0);

        run(8'h83, 8'h03, 0, "basic");
        run(8'hFF, 8'hFF, 0, "max");
        run(8'h01, 8'hA5, 0, "one");
        run(8'h00, 8'h7F, 0, "zero_mp");

        // Hold/resume: freeze after two steps, then continue.
        exp_q.push_back(model_product(8'h0F, 8'h11));
        do_load(8'h0F, 8'h11);
        step(1'b1);
        step(1'b1);
        repeat (3) begin
            step(1'b0);
            check("gap_product", 32'(bus.product), 32'(model_partial(8'h0F, 8'h11, 2)));
            check("gap_b0", 32'(bus.b0), 32'(model_b0(8'h0F, 2)));
        end
        drive_until_done(0, cycles);
        check("resume_latency", 32'(cycles + 2), 32'(model_latency(8'h0F)));
        repeat (3) step(1'b1);

        // Mid-run load aborts the first operation.
        do_load(8'hF0, 8'h02);
        repeat (3) step(1'b1);
        check("abort_zero_flag", 32'(bus.zero_flag), 32'd0);
        exp_q.push_back(model_product(8'h05, 8'h06));
        do_load(8'h05, 8'h06);
        check("reload_cleared", 32'(bus.product), 32'd0);
        drive_until_done(0, cycles);
        check("reload_latency", 32'(cycles), 32'(model_latency(8'h05)));
        repeat (3) step(1'b1);

        // Asynchronous reset between edges.
        do_load(8'h83, 8'h03);
        repeat (3) step(1'b1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        bus.load   = 1'b1;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("async_rst_edge");
        rst        = 1'b0;
        bus.load   = 1'b0;
        bus.enable = 1'b0;
        step(1'b0);

        // Random operands with random enable gaps.
        for (int t = 0; t < 24; t++) begin
            opnd_t mp;
            opnd_t mc;
            mp = opnd_t'($urandom);
            mc = opnd_t'($urandom);
            if (t % 8 == 0) mp = opnd_t'(1 << $urandom_range(0, N - 1));
            run(mp, mc, $urandom_range(0, 40), "rand");
        end

        repeat (2) step(1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
